compound_accumulator: RTL
=========================

COMPOUND_ACCUMULATOR -- requirements
Module: compound_accumulator

Interface
REQ-001 SHALL use types from package testbasic19_types: CompoundType = packed {mode (enum read=0/write=1), x (32-bit signed int), y (1-bit bool)}.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 b_in  input  CompoundType  transaction from the upstream producer.
REQ-006 b_in_sync  input  1  producer has b_in valid.
REQ-007 b_in_notify  output  1  block ready to accept b_in.
REQ-008 acc_out  output  CompoundType  result to the downstream consumer.
REQ-009 acc_out_sync  input  1  consumer ready to take acc_out.
REQ-010 acc_out_notify  output  1  acc_out valid.
REQ-011 txn_count  output  16  number of accepted b_in transactions, wrapping.

Function
REQ-012 An input transfer SHALL occur on a rising clk edge where b_in_sync=1 and b_in_notify=1; an output transfer SHALL occur on an edge where acc_out_notify=1 and acc_out_sync=1.
REQ-013 The state machine SHALL have states IDLE and SEND; IDLE drives b_in_notify=1, acc_out_notify=0; SEND drives b_in_notify=0, acc_out_notify=1.
REQ-014 On an IDLE transfer with mode=write, y=0: acc <= acc + x; state stays IDLE.
REQ-015 On an IDLE transfer with mode=write, y=1: acc <= x, ovf <= 0; state stays IDLE.
REQ-016 On an IDLE transfer with mode=read: acc_out <= {mode=write, x=acc, y=ovf}; state -> SEND; if b_in.y=1, acc <= 0 and ovf <= 0 in the same edge.
REQ-017 In SEND, acc_out SHALL remain stable until the output transfer; the transfer edge SHALL return the state to IDLE.
REQ-018 Latency: a read accepted on edge N SHALL raise acc_out_notify after edge N; with acc_out_sync held at 1, b_in_notify SHALL be 1 again after edge N+1.
REQ-019 ovf SHALL be a sticky flag set when a write-add produces signed 32-bit overflow (operands of equal sign, result of opposite sign).
REQ-020 txn_count SHALL increment by 1 on every input transfer (read or write) and wrap 0xFFFF -> 0x0000.
REQ-021 b_in_sync while in SEND SHALL be ignored; no acc or txn_count change.
REQ-022 acc_out_sync while in IDLE SHALL be ignored.

Reset
REQ-023 With rst=1 on an edge: state=IDLE, acc=0, ovf=0, txn_count=0, acc_out={read,0,0}, b_in_notify=1, acc_out_notify=0.
REQ-024 rst SHALL take priority over any simultaneous transfer; a pending SEND is discarded without an output transfer.

Configuration
REQ-025 Macro COMPOUND_ACC_SATURATE_EN: when defined, an overflowing write-add SHALL saturate acc to 0x7FFFFFFF (positive overflow) or 0x80000000 (negative) and set ovf.
REQ-026 When COMPOUND_ACC_SATURATE_EN is not defined, an overflowing add SHALL wrap modulo 2^32 and set ovf.

Verification
REQ-027 Reset, then writes {write,5,0},{write,-2,0},read y=0 with acc_out_sync=1 -> acc_out={write,3,0}, txn_count=3, acc stays 3.
REQ-028 Write {write,0x7FFFFFFF,1} then {write,1,0}, read -> macro off: x=0x80000000,y=1; macro on: x=0x7FFFFFFF,y=1.
REQ-029 Read with acc_out_sync=0 for 4 cycles while b_in_sync=1 with writes -> acc_out held, acc and txn_count unchanged, b_in_notify=0 until the sync cycle.
REQ-030 Acc=7, read with y=1 -> acc_out.x=7, following read returns x=0, y=0.
REQ-031 Assert rst during SEND -> next cycle acc_out_notify=0, b_in_notify=1, acc=0, txn_count=0.
REQ-032 Issue 65536 writes of 0 -> txn_count wraps to 0x0000.

Source files
------------

// File: rtl/compound_accumulator_if.sv
// Shared transaction type and the producer/consumer bus of compound_accumulator.
// The package is guarded so either file may be compiled first.
`ifndef TESTBASIC19_TYPES_SV
`define TESTBASIC19_TYPES_SV
package testbasic19_types;
   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mode_e;

   typedef struct packed {
      mode_e              mode;
      logic signed [31:0] x;
      logic               y;
   } CompoundType;
endpackage
`endif

interface compound_accumulator_if;
   import testbasic19_types::*;

   CompoundType b_in;
   logic        b_in_sync;
   logic        b_in_notify;
   CompoundType acc_out;
   logic        acc_out_sync;
   logic        acc_out_notify;
   logic [15:0] txn_count;

   // master: the producer/consumer side; slave: the accumulator
   modport master (
      output b_in, b_in_sync, acc_out_sync,
      input  b_in_notify, acc_out, acc_out_notify, txn_count
   );

   modport slave (
      input  b_in, b_in_sync, acc_out_sync,
      output b_in_notify, acc_out, acc_out_notify, txn_count
   );
endinterface

// File: rtl/compound_accumulator.sv
// Signed 32-bit accumulator with write/read transactions and a sticky overflow flag.
// Define COMPOUND_ACC_SATURATE_EN to saturate overflowing adds instead of wrapping.
`ifndef TESTBASIC19_TYPES_SV
`define TESTBASIC19_TYPES_SV
package testbasic19_types;
   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mode_e;

   typedef struct packed {
      mode_e              mode;
      logic signed [31:0] x;
      logic               y;
   } CompoundType;
endpackage
`endif

module compound_accumulator (
   input logic                   clk,
   input logic                   rst,
   compound_accumulator_if.slave bus
);
   import testbasic19_types::*;

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

   state_e             state, state_nx;
   logic signed [31:0] acc, acc_nx;
   logic               ovf, ovf_nx;
   CompoundType        acc_out_r, acc_out_nx;
   logic [15:0]        txn_count_r, txn_count_nx;
   logic               in_notify, out_notify;

   logic signed [31:0] sum;
   logic signed [31:0] add_res;
   logic               add_ovf;

   // Overflow only when both operands share a sign the result does not.
   always_comb begin
      sum     = acc + bus.b_in.x;
      add_ovf = (acc[31] == bus.b_in.x[31]) && (sum[31] != acc[31]);
`ifdef COMPOUND_ACC_SATURATE_EN
      if (add_ovf)
         add_res = acc[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
      else
         add_res = sum;
`else
      add_res = sum;
`endif
   end

   always_comb begin
      state_nx     = state;
      acc_nx       = acc;
      ovf_nx       = ovf;
      acc_out_nx   = acc_out_r;
      txn_count_nx = txn_count_r;
      in_notify    = 1'b0;
      out_notify   = 1'b0;

      case (state)
         IDLE: begin
            in_notify = 1'b1;
            if (bus.b_in_sync) begin
               txn_count_nx = txn_count_r + 16'd1;
               if (bus.b_in.mode == WRITE) begin
                  if (bus.b_in.y) begin
                     acc_nx = bus.b_in.x;
                     ovf_nx = 1'b0;
                  end else begin
                     acc_nx = add_res;
                     ovf_nx = ovf | add_ovf;
                  end
               end else begin
                  acc_out_nx = '{mode: WRITE, x: acc, y: ovf};
                  state_nx   = SEND;
                  if (bus.b_in.y) begin
                     acc_nx = '0;
                     ovf_nx = 1'b0;
                  end
               end
            end
         end

         SEND: begin
            out_notify = 1'b1;
            if (bus.acc_out_sync)
               state_nx = IDLE;
         end

         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         ovf         <= 1'b0;
         acc_out_r   <= '{mode: READ, x: '0, y: 1'b0};
         txn_count_r <= '0;
      end else begin
         state       <= state_nx;
         acc         <= acc_nx;
         ovf         <= ovf_nx;
         acc_out_r   <= acc_out_nx;
         txn_count_r <= txn_count_nx;
      end
   end

   assign bus.b_in_notify    = in_notify;
   assign bus.acc_out_notify = out_notify;
   assign bus.acc_out        = acc_out_r;
   assign bus.txn_count      = txn_count_r;
endmodule
